// File: rtl/button_event_gen.sv
// Button event generator: turns a clean button level into single-cycle
// press / release / auto-repeat step / long-press events, plus a held flag
// and a saturating count of auto-repeat steps since the last press.
module button_event_gen #(
   parameter int unsigned REPEAT_DELAY  = 32'd50_000_000,
   parameter int unsigned REPEAT_PERIOD = 32'd10_000_000,
   parameter int unsigned LONG_PRESS    = 32'd100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       step_pulse,
   output logic       long_pulse,
   output logic       held,
   output logic [7:0] repeat_count
);

   localparam logic [31:0] DelayTgt  = 32'(REPEAT_DELAY);
   localparam logic [31:0] PeriodTgt = 32'(REPEAT_PERIOD);
   localparam logic [31:0] LongTgt   = 32'(LONG_PRESS);

   typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

   state_e      state_q, state_d;
   logic        level_q;
   // Cycles since the press edge; parks at LONG_PRESS so it can never wrap.
   logic [31:0] hold_cnt_q, hold_cnt_d;
   // Cycles since the press (HOLD) or since the last step (REPEAT); reset on
   // every step so it stays below max(REPEAT_DELAY, REPEAT_PERIOD).
   logic [31:0] rep_cnt_q, rep_cnt_d;
   logic        long_done_q, long_done_d;
   logic [7:0]  repeat_count_d;
   logic        press_d, release_d, step_d, long_d, held_d;

   logic        rise, fall;
   logic [31:0] hold_cnt_inc, rep_cnt_inc;
   logic        step_due;

   assign rise         = level & ~level_q;
   assign fall         = ~level & level_q;
   assign hold_cnt_inc = hold_cnt_q + 32'd1;
   assign rep_cnt_inc  = rep_cnt_q + 32'd1;
   assign step_due     = ((state_q == StHold) && (rep_cnt_inc == DelayTgt)) ||
                         ((state_q == StRepeat) && (rep_cnt_inc == PeriodTgt));

   // Next-state, counters and next values of the registered outputs.
   always_comb begin
      state_d        = state_q;
      hold_cnt_d     = hold_cnt_q;
      rep_cnt_d      = rep_cnt_q;
      long_done_d    = long_done_q;
      repeat_count_d = repeat_count;
      press_d        = 1'b0;
      release_d      = 1'b0;
      step_d         = 1'b0;
      long_d         = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A fall here is impossible with a consistent level_q; ignore it.
            if (rise) begin
               press_d        = 1'b1;
               step_d         = 1'b1;
               repeat_count_d = 8'd0;
               hold_cnt_d     = 32'd0;
               rep_cnt_d      = 32'd0;
               long_done_d    = 1'b0;
               state_d        = StHold;
            end
         end
         StHold, StRepeat: begin
            if (fall) begin
               // Release wins over any step or long press due this edge.
               release_d = 1'b1;
               state_d   = StIdle;
            end else begin
               if (hold_cnt_q != LongTgt) begin
                  hold_cnt_d = hold_cnt_inc;
                  if ((hold_cnt_inc == LongTgt) && !long_done_q) begin
                     long_d      = 1'b1;
                     long_done_d = 1'b1;
                  end
               end
               rep_cnt_d = rep_cnt_inc;
               if (step_due) begin
                  step_d    = 1'b1;
                  rep_cnt_d = 32'd0;
                  state_d   = StRepeat;
                  if (repeat_count != 8'hFF) begin
                     repeat_count_d = repeat_count + 8'd1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      held_d = (state_d != StIdle);
   end

   // State, counters and all outputs registered; synchronous reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         level_q       <= 1'b0;
         hold_cnt_q    <= 32'd0;
         rep_cnt_q     <= 32'd0;
         long_done_q   <= 1'b0;
         repeat_count  <= 8'd0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         step_pulse    <= 1'b0;
         long_pulse    <= 1'b0;
         held          <= 1'b0;
      end else begin
         state_q       <= state_d;
         level_q       <= level;
         hold_cnt_q    <= hold_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         long_done_q   <= long_done_d;
         repeat_count  <= repeat_count_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         step_pulse    <= step_d;
         long_pulse    <= long_d;
         held          <= held_d;
      end
   end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed scenarios with hand-computed
// expectations plus a random level/reset phase, all checked every cycle
// against a time-based model of the event schedule.
module tb_button_event_gen;

   localparam int RD = 10;
   localparam int RP = 4;
   localparam int LP = 20;
   localparam int LOGN = 1300;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       level = 1'b0;
   logic       press_pulse, release_pulse, step_pulse, long_pulse, held;
   logic [7:0] repeat_count;

   int n_checks = 0;
   int n_fails  = 0;

   button_event_gen #(
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP),
      .LONG_PRESS   (LP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .level        (level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .step_pulse   (step_pulse),
      .long_pulse   (long_pulse),
      .held         (held),
      .repeat_count (repeat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: expected outputs follow from the edge index of the press and the
   // number of edges elapsed since it.
   int   e_idx = 0;
   int   m_p = 0;
   bit   m_prev = 0;
   bit   m_in_hold = 0;
   int   m_rc = 0;
   bit   m_valid = 0;
   bit   x_press, x_release, x_step, x_long, x_held;
   int   x_rc;

   initial begin
      forever begin
         @(posedge clk);
         x_press = 0; x_release = 0; x_step = 0; x_long = 0;
         if (rst) begin
            m_prev = 0; m_in_hold = 0; m_rc = 0; m_valid = 1;
         end else begin
            if (!m_in_hold && level && !m_prev) begin
               x_press = 1; x_step = 1; m_p = e_idx; m_rc = 0; m_in_hold = 1;
            end else if (m_in_hold && !level && m_prev) begin
               x_release = 1; m_in_hold = 0;
            end else if (m_in_hold) begin
               int d;
               d = e_idx - m_p;
               if (d >= RD && ((d - RD) % RP) == 0) begin
                  x_step = 1;
                  if (m_rc < 255) m_rc++;
               end
               if (d == LP) x_long = 1;
            end
            m_prev = level;
         end
         x_held = m_in_hold;
         x_rc   = m_rc;
         e_idx++;
      end
   end

   // Compare the DUT against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("press_pulse", 32'(press_pulse), 32'(x_press));
            check("release_pulse", 32'(release_pulse), 32'(x_release));
            check("step_pulse", 32'(step_pulse), 32'(x_step));
            check("long_pulse", 32'(long_pulse), 32'(x_long));
            check("held", 32'(held), 32'(x_held));
            check("repeat_count", 32'(repeat_count), 32'(x_rc));
         end
      end
   end

   logic press_log[LOGN];
   logic rel_log[LOGN];
   logic step_log[LOGN];
   logic long_log[LOGN];
   logic held_log[LOGN];
   int   rc_log[LOGN];

   // Raise level now; entry i of the logs is sampled just after edge P+i.
   // rel_at > 0 makes the fall be registered at edge P+rel_at.
   task automatic run_press(input int rel_at, input int len);
      level = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         press_log[i] = press_pulse;
         rel_log[i]   = release_pulse;
         step_log[i]  = step_pulse;
         long_log[i]  = long_pulse;
         held_log[i]  = held;
         rc_log[i]    = int'(repeat_count);
         if (rel_at > 0 && i == rel_at - 1) level = 1'b0;
      end
      level = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   function automatic int count_ones(input int sel, input int len);
      int c;
      c = 0;
      for (int i = 0; i < len; i++) begin
         if (sel == 0 && step_log[i]) c++;
         if (sel == 1 && long_log[i]) c++;
         if (sel == 2 && rel_log[i]) c++;
      end
      return c;
   endfunction

   initial begin
      rst = 1'b1;
      level = 1'b0;
      repeat (3) @(negedge clk);
      check("reset held", 32'(held), 32'd0);
      check("reset repeat_count", 32'(repeat_count), 32'd0);
      check("reset step_pulse", 32'(step_pulse), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Long hold, release after 30 cycles.
      run_press(0, 30);
      check("t1 press at P", 32'(press_log[0]), 32'd1);
      check("t1 step at P", 32'(step_log[0]), 32'd1);
      check("t1 step P+10", 32'(step_log[10]), 32'd1);
      check("t1 step P+14", 32'(step_log[14]), 32'd1);
      check("t1 step P+18", 32'(step_log[18]), 32'd1);
      check("t1 step P+22", 32'(step_log[22]), 32'd1);
      check("t1 step P+26", 32'(step_log[26]), 32'd1);
      check("t1 step count", 32'(count_ones(0, 30)), 32'd6);
      check("t1 long P+20", 32'(long_log[20]), 32'd1);
      check("t1 long count", 32'(count_ones(1, 30)), 32'd1);
      check("t1 rc P+27", 32'(rc_log[27]), 32'd5);

      // Short hold, fall registered at P+5.
      run_press(5, 8);
      check("t2 release P+5", 32'(rel_log[5]), 32'd1);
      check("t2 held P+4", 32'(held_log[4]), 32'd1);
      check("t2 held P+5", 32'(held_log[5]), 32'd0);
      check("t2 step count", 32'(count_ones(0, 8)), 32'd1);
      check("t2 rc", 32'(rc_log[7]), 32'd0);

      // Fall coincides with the second step.
      run_press(14, 18);
      check("t3 release P+14", 32'(rel_log[14]), 32'd1);
      check("t3 no step P+14", 32'(step_log[14]), 32'd0);
      check("t3 rc after", 32'(rc_log[17]), 32'd1);

      // Fall coincides with a step and the long press.
      run_press(20, 24);
      check("t4 release P+20", 32'(rel_log[20]), 32'd1);
      check("t4 no step P+20", 32'(step_log[20]), 32'd0);
      check("t4 no long", 32'(count_ones(1, 24)), 32'd0);

      // Saturation of repeat_count.
      run_press(0, 1200);
      check("t5 rc P+1025", 32'(rc_log[1025]), 32'd254);
      check("t5 rc P+1026", 32'(rc_log[1026]), 32'd255);
      check("t5 rc P+1199", 32'(rc_log[1199]), 32'd255);
      check("t5 step P+1198", 32'(step_log[1198]), 32'd1);
      check("t5 step count", 32'(count_ones(0, 1200)), 32'd299);
      check("t5 long count", 32'(count_ones(1, 1200)), 32'd1);

      // Reset at P+12 while held, deasserted with level still high.
      level = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) check("t6 press P", 32'(press_pulse), 32'd1);
         if (i == 11) rst = 1'b1;
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("t6 rst outputs", {26'd0, press_pulse, release_pulse, step_pulse, long_pulse,
                                  held, 1'b0} | 32'(repeat_count), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("t6 repress", 32'(press_pulse), 32'd1);
      check("t6 rc", 32'(repeat_count), 32'd0);
      check("t6 held", 32'(held), 32'd1);
      level = 1'b0;
      repeat (4) @(negedge clk);

      // Random level activity with occasional resets.
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
         end
         level = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end else begin
            repeat ($urandom_range(1, 35)) @(negedge clk);
         end
      end
      level = 1'b0;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
